// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared core types: request sequencer states and defaults
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

    localparam int REQ_TIMEOUT_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear, optionally saturating at all-ones
module sat_counter #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && !(SATURATE && (&count_q))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - fetch/data request sequencer with PC-advance strobe and stall watchdog
// Optional REQ_STATS_EN adds instruction, data-access and stall counters.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_W = REQ_TIMEOUT_W_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dren_dec,
    input  logic        dwen_dec,
    input  logic        halt_dec,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        pc_en,
    output logic        halt,
    output logic        timeout
`ifdef REQ_STATS_EN
    ,
    output logic [31:0] instr_cnt,
    output logic [31:0] data_cnt,
    output logic [31:0] stall_cnt
`endif
);

    reqstate_t state_q, state_d;
    logic      dren_q, dren_d;
    logic      dwen_q, dwen_d;
    logic      wd_en, wd_clr, data_done;
    logic [TIMEOUT_W-1:0] wd_count;

    always_comb begin
        state_d   = state_q;
        dren_d    = dren_q;
        dwen_d    = dwen_q;
        pc_en     = 1'b0;
        wd_en     = 1'b0;
        wd_clr    = 1'b0;
        data_done = 1'b0;
        case (state_q)
            FETCH: begin
                if (ihit) begin
                    if (halt_dec) begin
                        state_d = HALTED;
                    end else if (dren_dec || dwen_dec) begin
                        // a combined load+store decode is treated as a store
                        state_d = DATA;
                        dwen_d  = dwen_dec;
                        dren_d  = dren_dec & ~dwen_dec;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    pc_en     = 1'b1;
                    data_done = 1'b1;
                    wd_clr    = 1'b1;
                    state_d   = FETCH;
                    dren_d    = 1'b0;
                    dwen_d    = 1'b0;
                end else begin
                    wd_en = 1'b1;
                end
            end
            HALTED: begin
                dren_d = 1'b0;
                dwen_d = 1'b0;
            end
            default: begin
                state_d = FETCH;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
        end
    end

    assign iREN = (state_q == FETCH);
    assign halt = (state_q == HALTED);
    assign dREN = dren_q;
    assign dWEN = dwen_q;

    sat_counter #(.W(TIMEOUT_W), .SATURATE(1'b1)) u_watchdog (
        .clk   (CLK),
        .rst_n (nRST),
        .clear (wd_clr),
        .en    (wd_en),
        .count (wd_count)
    );

    assign timeout = &wd_count;

`ifdef REQ_STATS_EN
    logic stall_en;

    // HALTED drives no requests, so every enable is naturally frozen there
    assign stall_en = (iREN & ~ihit) | ((dren_q | dwen_q) & ~dhit);

    sat_counter #(.W(32), .SATURATE(1'b0)) u_instr_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .clear (1'b0),
        .en    (pc_en),
        .count (instr_cnt)
    );

    sat_counter #(.W(32), .SATURATE(1'b0)) u_data_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .clear (1'b0),
        .en    (data_done),
        .count (data_cnt)
    );

    sat_counter #(.W(32), .SATURATE(1'b0)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .clear (1'b0),
        .en    (stall_en),
        .count (stall_cnt)
    );
`endif

endmodule
